l1_unified_cache: RTL and testbench

- Direct-mapped, write-back, write-allocate cache between the multicycle rv32i `cpu` memory port and physical memory.
- CPU side is the `cpu` 32-bit word interface, one outstanding request held until `mem_resp`.
- Memory side transfers whole 256-bit lines with a `pmem_resp` handshake.
- Hits complete in the request cycle; misses run writeback (if dirty) then fill.

---
 rtl/l1_unified_cache_if.sv | 40 ++++
 rtl/l1_unified_cache.sv | 132 +++++++++++++
 tb/tb_l1_unified_cache.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_unified_cache_if.sv
// CPU word port and memory line port of the L1 unified cache, bundled.
//
// Handshake: the requester raises mem_read/mem_write (or pmem_read/pmem_write)
// together with address/data and holds every one of them stable until the
// responder pulses mem_resp (or pmem_resp) high for exactly one cycle; the
// transfer completes at the clock edge that samples the pulse. Read data is
// valid only in the response cycle.
interface l1_unified_cache_if;
  // CPU side: 32-bit word requests
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  // Memory side: whole 256-bit line transfers
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  // Cache view: serves the CPU, issues line transfers to memory
  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata
  );

  // Environment view: CPU driver plus physical memory
  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata
  );
endinterface

// File: rtl/l1_unified_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache with 32-byte lines.
// Hits respond combinationally in the request cycle; misses write back the
// dirty victim (if any) and then fill the line before responding from IDLE.
module l1_unified_cache #(
  parameter int NUM_SETS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  l1_unified_cache_if.slave    bus,
  output logic [1:0]           dbg_state
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 27 - IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  state_t              state;
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [255:0]        data_q [NUM_SETS];

  // Set and tag of the miss in progress, captured on entry so that a CPU
  // address change mid-miss cannot redirect the outstanding line transfer.
  logic [IDX_W-1:0]    miss_idx;
  logic [TAG_W-1:0]    miss_tag;

  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [2:0]          word_sel;
  logic [7:0]          word_base;
  logic                req;
  logic                hit;
  logic                unused_addr_bits;

  assign req_idx          = bus.mem_address[4+IDX_W:5];
  assign req_tag          = bus.mem_address[31:5+IDX_W];
  assign word_sel         = bus.mem_address[4:2];
  assign word_base        = {word_sel, 5'b0};
  assign req              = bus.mem_read | bus.mem_write;
  assign hit              = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_addr_bits = ^bus.mem_address[1:0];
  assign dbg_state        = state;

  // Output decode: purely a function of the registered state and the lookup
  always_comb begin
    bus.mem_resp     = 1'b0;
    bus.mem_rdata    = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    case (state)
      IDLE: begin
        if (req && hit) begin
          bus.mem_resp  = 1'b1;
          // Old word is returned even for a combined read+write request
          bus.mem_rdata = data_q[req_idx][word_base +: 32];
        end
      end
      WRITEBACK: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {tag_q[miss_idx], miss_idx, 5'b0};
        bus.pmem_wdata   = data_q[miss_idx];
      end
      FILL: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {miss_tag, miss_idx, 5'b0};
      end
      default: ;
    endcase
  end

  // Control FSM plus valid/dirty bookkeeping; reset abandons any miss
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      valid_q  <= '0;
      dirty_q  <= '0;
      miss_idx <= '0;
      miss_tag <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              // A write hit always dirties the line, even with no lanes enabled
              if (bus.mem_write) dirty_q[req_idx] <= 1'b1;
            end else begin
              miss_idx <= req_idx;
              miss_tag <= req_tag;
              state    <= dirty_q[req_idx] ? WRITEBACK : FILL;
            end
          end
        end
        WRITEBACK: begin
          if (bus.pmem_resp) begin
            dirty_q[miss_idx] <= 1'b0;
            state             <= FILL;
          end
        end
        FILL: begin
          if (bus.pmem_resp) begin
            valid_q[miss_idx] <= 1'b1;
            dirty_q[miss_idx] <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line data and tag storage: byte-lane merge on write hits, install on fill
  always_ff @(posedge clk) begin
    if (state == IDLE && req && hit && bus.mem_write) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.mem_byte_enable[i])
          data_q[req_idx][word_base + 8'(i * 8) +: 8] <= bus.mem_wdata[i*8 +: 8];
      end
    end else if (state == FILL && bus.pmem_resp) begin
      data_q[miss_idx] <= bus.pmem_rdata;
      tag_q[miss_idx]  <= miss_tag;
    end
  end

endmodule

// File: tb/tb_l1_unified_cache.sv
// Bench for l1_unified_cache: directed scenarios followed by random traffic,
// all checked against an architectural memory image plus cache metadata model.
module tb_l1_unified_cache;

  localparam int NUM_SETS = 8;
  localparam int MAX_CYC  = 64;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  l1_unified_cache_if bus ();

  l1_unified_cache #(.NUM_SETS(NUM_SETS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mem_line: contents held by physical memory; arch_line: what the CPU
  // should observe. They differ only for lines dirty in the cache.
  logic [255:0] mem_line  [logic [31:0]];
  logic [255:0] arch_line [logic [31:0]];
  bit           m_valid [NUM_SETS];
  bit           m_dirty [NUM_SETS];
  logic [23:0]  m_tag   [NUM_SETS];

  logic [31:0]  exp_q [$];
  int           checks   = 0;
  int           failures = 0;

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom();
    return l;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.mem_address     = '0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = '0;
    bus.mem_wdata       = '0;
    bus.pmem_rdata      = '0;
    bus.pmem_resp       = 1'b0;
  endtask

  // Issues one CPU access (caller is at posedge+1), plays physical memory,
  // and checks the whole transaction. dly < 0 picks random memory latency.
  task automatic do_access(input logic [31:0] addr, input bit rd, input bit wr,
                           input logic [3:0] be, input logic [31:0] wd,
                           input int dly, output logic [31:0] rdata,
                           output logic [255:0] wb_data);
    int           idx;
    int           w;
    logic [23:0]  tag;
    logic [31:0]  line;
    logic [31:0]  victim;
    logic [255:0] lv;
    bit           exp_hit;
    bit           exp_wb;
    bit           done;
    bit           seen_wb;
    bit           seen_fill;
    int           wait_cnt;
    int           pd;
    int           wb_len;
    int           fill_len;
    int           resp_cyc;
    int           exp_cyc;
    logic [31:0]  exp_rd;

    idx    = int'(addr[7:5]);
    tag    = addr[31:8];
    w      = int'(addr[4:2]);
    line   = {addr[31:5], 5'b0};
    victim = {m_tag[idx], addr[7:5], 5'b0};
    if (!mem_line.exists(line)) begin
      mem_line[line]  = rand_line();
      arch_line[line] = mem_line[line];
    end
    exp_hit = m_valid[idx] && (m_tag[idx] == tag);
    exp_wb  = !exp_hit && m_dirty[idx];
    lv      = arch_line[line];
    if (rd) exp_q.push_back(lv[w*32 +: 32]);

    bus.mem_address     = addr;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_byte_enable = be;
    bus.mem_wdata       = wd;

    done = 0; seen_wb = 0; seen_fill = 0; wait_cnt = 0; pd = 0;
    wb_len = 0; fill_len = 0; resp_cyc = -1; rdata = '0; wb_data = '0;
    for (int cyc = 0; cyc < MAX_CYC && !done; cyc++) begin
      @(negedge clk);
      checks++;
      if (bus.pmem_read && bus.pmem_write) begin
        failures++;
        $display("FAIL pmem_exclusive addr=%h cyc=%0d both read and write high", addr, cyc);
      end
      checks++;
      if (bus.mem_resp && (bus.pmem_read || bus.pmem_write)) begin
        failures++;
        $display("FAIL resp_outside_idle addr=%h cyc=%0d mem_resp with pmem active", addr, cyc);
      end
      if (bus.mem_resp) begin
        done     = 1;
        resp_cyc = cyc;
        rdata    = bus.mem_rdata;
      end else if (bus.pmem_write) begin
        if (!seen_wb) begin
          seen_wb  = 1;
          wait_cnt = 0;
          pd       = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
          checks++;
          if (bus.pmem_address !== victim) begin
            failures++;
            $display("FAIL wb_address got=%h exp=%h", bus.pmem_address, victim);
          end
          checks++;
          if (arch_line.exists(victim) && bus.pmem_wdata !== arch_line[victim]) begin
            failures++;
            $display("FAIL wb_data addr=%h got=%h exp=%h", victim, bus.pmem_wdata, arch_line[victim]);
          end
          wb_data = bus.pmem_wdata;
        end
        checks++;
        if (seen_fill) begin
          failures++;
          $display("FAIL wb_after_fill addr=%h cyc=%0d got=write exp=no write", addr, cyc);
        end
        if (wait_cnt == pd) begin
          bus.pmem_resp    = 1'b1;
          mem_line[victim] = bus.pmem_wdata;
          wb_len           = pd + 1;
        end else begin
          wait_cnt++;
        end
      end else if (bus.pmem_read) begin
        if (!seen_fill) begin
          seen_fill = 1;
          wait_cnt  = 0;
          pd        = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
          checks++;
          if (bus.pmem_address !== line) begin
            failures++;
            $display("FAIL fill_address got=%h exp=%h", bus.pmem_address, line);
          end
        end
        if (wait_cnt == pd) begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = mem_line[line];
          fill_len       = pd + 1;
        end else begin
          wait_cnt++;
        end
      end
      @(posedge clk);
      #1;
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
    end
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;

    checks++;
    if (!done) begin
      failures++;
      $display("FAIL timeout addr=%h got=no mem_resp exp=mem_resp within %0d cycles", addr, MAX_CYC);
    end
    checks++;
    if (seen_wb != exp_wb) begin
      failures++;
      $display("FAIL writeback_seen addr=%h got=%0d exp=%0d", addr, seen_wb, exp_wb);
    end
    checks++;
    if (seen_fill != !exp_hit) begin
      failures++;
      $display("FAIL fill_seen addr=%h got=%0d exp=%0d", addr, seen_fill, !exp_hit);
    end
    exp_cyc = exp_hit ? 0 : (1 + wb_len + fill_len);
    checks++;
    if (done && resp_cyc != exp_cyc) begin
      failures++;
      $display("FAIL latency addr=%h got=%0d exp=%0d", addr, resp_cyc, exp_cyc);
    end
    if (rd) begin
      exp_rd = exp_q.pop_front();
      checks++;
      if (rdata !== exp_rd) begin
        failures++;
        $display("FAIL read_data addr=%h got=%h exp=%h", addr, rdata, exp_rd);
      end
    end

    // Advance the model: allocate on miss, then apply the write
    if (!exp_hit) begin
      m_valid[idx] = 1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 0;
    end
    if (wr) begin
      lv = arch_line[line];
      for (int i = 0; i < 4; i++)
        if (be[i]) lv[w*32 + i*8 +: 8] = wd[i*8 +: 8];
      arch_line[line] = lv;
      m_dirty[idx]    = 1;
    end
  endtask

  task automatic check_idle_outputs(input string tag_name);
    @(negedge clk);
    checks++;
    if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 ||
        bus.mem_rdata !== 32'h0 || bus.pmem_address !== 32'h0 || bus.pmem_wdata !== 256'h0 ||
        dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL %s resp=%b rd=%b wr=%b rdata=%h paddr=%h state=%0d exp=all zero",
               tag_name, bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.mem_rdata,
               bus.pmem_address, dbg_state);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < NUM_SETS; s++) begin
      m_valid[s] = 0;
      m_dirty[s] = 0;
      m_tag[s]   = '0;
    end
    // Dirty data held only in the cache is lost on reset
    foreach (mem_line[k]) arch_line[k] = mem_line[k];
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    model_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 ||
        bus.mem_rdata !== 32'h0 || bus.pmem_address !== 32'h0 || bus.pmem_wdata !== 256'h0) begin
      failures++;
      $display("FAIL reset_outputs resp=%b rd=%b wr=%b rdata=%h paddr=%h exp=all zero",
               bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.mem_rdata, bus.pmem_address);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_cold_fill();
    logic [255:0] l;
    logic [31:0]  rdata;
    logic [255:0] wb;
    l = rand_line();
    l[31:0]  = 32'h1111_1111;
    l[63:32] = 32'h0;
    mem_line[32'h40]  = l;
    arch_line[32'h40] = l;
    do_access(32'h0000_0040, 1, 0, 4'h0, 32'h0, 3, rdata, wb);
    checks++;
    if (rdata !== 32'h1111_1111) begin
      failures++;
      $display("FAIL cold_fill_word0 got=%h exp=11111111", rdata);
    end
  endtask

  task automatic test_write_hit_lanes();
    logic [31:0]  rdata;
    logic [255:0] wb;
    do_access(32'h0000_0044, 0, 1, 4'b0101, 32'hAABB_CCDD, 0, rdata, wb);
    do_access(32'h0000_0044, 1, 0, 4'h0, 32'h0, 0, rdata, wb);
    checks++;
    if (rdata !== 32'h00BB_00DD) begin
      failures++;
      $display("FAIL byte_lane_merge got=%h exp=00bb00dd", rdata);
    end
  endtask

  task automatic test_dirty_conflict();
    logic [31:0]  rdata;
    logic [255:0] wb;
    do_access(32'h0000_0140, 1, 0, 4'h0, 32'h0, 2, rdata, wb);
    checks++;
    if (wb[63:32] !== 32'h00BB_00DD) begin
      failures++;
      $display("FAIL wb_word1 got=%h exp=00bb00dd", wb[63:32]);
    end
  endtask

  task automatic test_clean_conflict();
    logic [31:0]  rdata;
    logic [255:0] wb;
    do_access(32'h0000_0040, 1, 0, 4'h0, 32'h0, 1, rdata, wb);
    do_access(32'h0000_0240, 1, 0, 4'h0, 32'h0, 1, rdata, wb);
  endtask

  task automatic test_read_write_both();
    logic [31:0]  rdata;
    logic [255:0] wb;
    do_access(32'h0000_0248, 1, 1, 4'b1111, 32'h1234_5678, 0, rdata, wb);
    do_access(32'h0000_0248, 1, 0, 4'h0, 32'h0, 0, rdata, wb);
    checks++;
    if (rdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL rw_both_read got=%h exp=12345678", rdata);
    end
    do_access(32'h0000_0040, 1, 0, 4'h0, 32'h0, 1, rdata, wb);
    checks++;
    if (wb[95:64] !== 32'h1234_5678) begin
      failures++;
      $display("FAIL rw_both_evict got=%h exp=12345678", wb[95:64]);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0]  rdata;
    logic [255:0] wb;
    bit           in_fill;
    in_fill = 0;
    do_access(32'h0000_0040, 1, 0, 4'h0, 32'h0, 0, rdata, wb);
    if (!mem_line.exists(32'h1040)) begin
      mem_line[32'h1040]  = rand_line();
      arch_line[32'h1040] = mem_line[32'h1040];
    end
    bus.mem_address = 32'h0000_1040;
    bus.mem_read    = 1'b1;
    for (int cyc = 0; cyc < MAX_CYC && !in_fill; cyc++) begin
      @(negedge clk);
      if (bus.pmem_read) begin
        in_fill = 1;
      end else begin
        if (bus.pmem_write) begin
          bus.pmem_resp = 1'b1;
          mem_line[bus.pmem_address] = bus.pmem_wdata;
        end
        @(posedge clk);
        #1;
        bus.pmem_resp = 1'b0;
      end
    end
    checks++;
    if (!in_fill) begin
      failures++;
      $display("FAIL reach_fill got=no pmem_read exp=pmem_read within %0d cycles", MAX_CYC);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL async_reset_drop rd=%b wr=%b state=%0d exp=0 0 0",
               bus.pmem_read, bus.pmem_write, dbg_state);
    end
    bus.mem_read = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Stray memory response while idle must be ignored
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = rand_line();
    @(posedge clk);
    #1;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    check_idle_outputs("stray_pmem_resp");
    do_access(32'h0000_0040, 1, 0, 4'h0, 32'h0, 0, rdata, wb);
  endtask

  task automatic test_random();
    logic [31:0]  addr;
    logic [31:0]  rdata;
    logic [255:0] wb;
    int           op;
    for (int n = 0; n < 200; n++) begin
      addr = {22'h0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      op   = int'($urandom_range(0, 2));
      do_access(addr, op != 1, op != 0, 4'($urandom_range(0, 15)), $urandom(), -1, rdata, wb);
      if ($urandom_range(0, 7) == 0) check_idle_outputs("random_idle");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0]  rdata;
    logic [255:0] wb;
    for (int s = 0; s < NUM_SETS; s++)
      do_access(32'h0000_3000 | (s << 5), 0, 1, 4'b1111, 32'hC0DE_0000 + s, -1, rdata, wb);
    for (int s = 0; s < NUM_SETS; s++)
      do_access(32'h0000_3000 | (s << 5), 1, 0, 4'h0, 32'h0, -1, rdata, wb);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_cold_fill();
    test_write_hit_lanes();
    test_dirty_conflict();
    test_clean_conflict();
    test_read_write_both();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
